// File: rtl/memoredf_pkg.sv
// Shared types and defaults for the non-AXI domain scheduler.
//   mode_t      : scheduling policy selector (TDMA slots or earliest-deadline-first)
//   qidx_t      : queue index for the default queue count
//   DEF_*       : default parameter values used by domain_scheduler
package memoredf_pkg;

    localparam int unsigned DEF_NB_QUEUES     = 4;
    localparam int unsigned DEF_COUNTER_WIDTH = 32;
    localparam int unsigned DEF_MODE_WIDTH    = $clog2(2);
    localparam int unsigned DEF_QIDX_WIDTH    = $clog2(DEF_NB_QUEUES);

    typedef enum logic [0:0] {
        MODE_TDMA = 1'b0,
        MODE_EDF  = 1'b1
    } mode_t;

    typedef logic [DEF_QIDX_WIDTH-1:0] qidx_t;

endpackage

// File: rtl/edf_min_selector.sv
// Combinational argmin over the per-queue EDF countdowns.
//   countdowns : remaining deadline of every queue
//   eligible   : queues allowed to compete (non-empty)
//   min_index  : eligible queue with the smallest countdown, lowest index on ties
//   found      : at least one queue was eligible
module edf_min_selector #(
    parameter int unsigned NB_QUEUES     = 4,
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned IDX_WIDTH     = $clog2(NB_QUEUES)
) (
    input  logic [NB_QUEUES-1:0][COUNTER_WIDTH-1:0] countdowns,
    input  logic [NB_QUEUES-1:0]                    eligible,
    output logic [IDX_WIDTH-1:0]                    min_index,
    output logic                                    found
);

    logic [COUNTER_WIDTH-1:0] min_value;

    always_comb begin
        min_index = '0;
        found     = 1'b0;
        min_value = '1;
        for (int unsigned i = 0; i < NB_QUEUES; i++) begin
            // Strict less-than: an equal value at a higher index never displaces the winner.
            if (eligible[i] && (!found || (countdowns[i] < min_value))) begin
                found     = 1'b1;
                min_value = countdowns[i];
                min_index = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/domain_scheduler.sv
// Chooses which per-source packet queue of the non-AXI domain is served next.
//   clock, reset  : rising-edge clock, synchronous active-low reset
//   mode          : 0 = TDMA fixed slots, 1 = EDF earliest remaining deadline
//   periods       : TDMA slot length / EDF release period per queue (cycles)
//   deadlines     : EDF relative deadline per queue (cycles)
//   queue_empty   : per-queue empty flag
//   consumed      : downstream took the packet of the selected queue
//   select        : granted queue index, held until consumed
//   select_valid  : select is meaningful
//   pop           : combinational one-hot dequeue pulse
//   deadline_miss : one-cycle pulse when a non-empty queue's countdown reaches 0
module domain_scheduler
    import memoredf_pkg::*;
#(
    parameter int unsigned NB_QUEUES     = DEF_NB_QUEUES,
    parameter int unsigned COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int unsigned MODE_WIDTH    = DEF_MODE_WIDTH
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [MODE_WIDTH-1:0]                   mode,
    input  logic [NB_QUEUES-1:0][COUNTER_WIDTH-1:0] periods,
    input  logic [NB_QUEUES-1:0][COUNTER_WIDTH-1:0] deadlines,
    input  logic [NB_QUEUES-1:0]                    queue_empty,
    input  logic                                    consumed,
    output logic [$clog2(NB_QUEUES)-1:0]            select,
    output logic                                    select_valid,
    output logic [NB_QUEUES-1:0]                    pop,
    output logic [NB_QUEUES-1:0]                    deadline_miss
);

    localparam int unsigned IDX_WIDTH = $clog2(NB_QUEUES);

    typedef logic [COUNTER_WIDTH-1:0] cnt_t;
    typedef logic [IDX_WIDTH-1:0]     idx_t;

    localparam cnt_t ONE = cnt_t'(1);

    // Policy selection and mode-change detection
    logic [MODE_WIDTH-1:0] mode_q;
    logic                  is_edf;
    logic                  mode_changed;

    assign is_edf       = (mode_t'(mode[0]) == MODE_EDF);
    assign mode_changed = (mode != mode_q);

    logic [NB_QUEUES-1:0] period_nz;

    always_comb begin
        period_nz = '0;
        for (int unsigned i = 0; i < NB_QUEUES; i++) begin
            period_nz[i] = (periods[i] != '0);
        end
    end

    // TDMA slot rotation
    idx_t slot_q, slot_d, slot_after, cand_slot;
    cnt_t slot_cnt_q, slot_cnt_d;
    logic tdma_ok;

    // Next slot owner with a non-zero period; stays put if none exists.
    always_comb begin
        slot_after = slot_q;
        cand_slot  = slot_q;
        for (int k = int'(NB_QUEUES) - 1; k >= 1; k--) begin
            cand_slot = idx_t'((int'(slot_q) + k) % int'(NB_QUEUES));
            if (period_nz[cand_slot]) begin
                slot_after = cand_slot;
            end
        end
    end

    always_comb begin
        slot_d     = slot_q;
        slot_cnt_d = slot_cnt_q;
        if (mode_changed || is_edf) begin
            slot_d     = '0;
            slot_cnt_d = '0;
        end else if (!period_nz[slot_q] || (slot_cnt_q == periods[slot_q] - ONE)) begin
            // A zero-period owner is skipped immediately.
            slot_d     = slot_after;
            slot_cnt_d = '0;
        end else begin
            slot_cnt_d = slot_cnt_q + ONE;
        end
    end

    assign tdma_ok = period_nz[slot_q] && !queue_empty[slot_q];

    // EDF release timers and deadline countdowns
    cnt_t [NB_QUEUES-1:0] ptimer_q, ptimer_d, cdown_q, cdown_d;
    cnt_t [NB_QUEUES-1:0] load_ptimer, load_cdown;
    logic [NB_QUEUES-1:0] miss_q, miss_d;

    // Queues without releases are best effort: parked at the largest countdown.
    always_comb begin
        load_ptimer = periods;
        load_cdown  = deadlines;
        for (int unsigned i = 0; i < NB_QUEUES; i++) begin
            if (!period_nz[i]) begin
                load_cdown[i] = '1;
            end
        end
    end

    always_comb begin
        ptimer_d = ptimer_q;
        cdown_d  = cdown_q;
        miss_d   = '0;
        if (mode_changed) begin
            ptimer_d = load_ptimer;
            cdown_d  = load_cdown;
        end else if (is_edf) begin
            for (int unsigned i = 0; i < NB_QUEUES; i++) begin
                if (!period_nz[i]) begin
                    ptimer_d[i] = '0;
                    cdown_d[i]  = '1;
                end else if (ptimer_q[i] <= ONE) begin
                    // Also catches a timer left at 0 when the period was just raised.
                    ptimer_d[i] = periods[i];
                    cdown_d[i]  = deadlines[i];
                end else begin
                    ptimer_d[i] = ptimer_q[i] - ONE;
                    if (cdown_q[i] != '0) begin
                        cdown_d[i] = cdown_q[i] - ONE;
                    end
                    miss_d[i] = (cdown_q[i] == ONE) && !queue_empty[i];
                end
            end
        end
    end

    logic edf_found;
    idx_t edf_idx;

    edf_min_selector #(
        .NB_QUEUES     (NB_QUEUES),
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .IDX_WIDTH     (IDX_WIDTH)
    ) u_edf_min_selector (
        .countdowns (cdown_q),
        .eligible   (~queue_empty),
        .min_index  (edf_idx),
        .found      (edf_found)
    );

    // Grant register: frozen while a grant is outstanding and not consumed
    idx_t select_q, select_d;
    logic valid_q, valid_d;

    always_comb begin
        select_d = select_q;
        valid_d  = valid_q;
        if (!valid_q || consumed) begin
            if (is_edf) begin
                valid_d = edf_found;
                if (edf_found) begin
                    select_d = edf_idx;
                end
            end else begin
                valid_d = tdma_ok;
                if (tdma_ok) begin
                    select_d = slot_q;
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < NB_QUEUES; i++) begin
            pop[i] = consumed && valid_q && (select_q == idx_t'(i));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mode_q     <= mode;
            slot_q     <= '0;
            slot_cnt_q <= '0;
            ptimer_q   <= load_ptimer;
            cdown_q    <= load_cdown;
            miss_q     <= '0;
            select_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            mode_q     <= mode;
            slot_q     <= slot_d;
            slot_cnt_q <= slot_cnt_d;
            ptimer_q   <= ptimer_d;
            cdown_q    <= cdown_d;
            miss_q     <= miss_d;
            select_q   <= select_d;
            valid_q    <= valid_d;
        end
    end

    assign select        = select_q;
    assign select_valid  = valid_q;
    assign deadline_miss = miss_q;

endmodule

// File: tb/tb_domain_scheduler.sv
module tb_domain_scheduler;

    localparam int unsigned NQ = 4;
    localparam int unsigned CW = 32;
    localparam int unsigned MW = 1;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [MW-1:0]          mode = '0;
    logic [NQ-1:0][CW-1:0]  periods = '0;
    logic [NQ-1:0][CW-1:0]  deadlines = '0;
    logic [NQ-1:0]          queue_empty = '1;
    logic                   consumed = 1'b0;
    logic [1:0]             select;
    logic                   select_valid;
    logic [NQ-1:0]          pop;
    logic [NQ-1:0]          deadline_miss;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [NQ-1:0] exp_pop_q[$];
    logic [NQ-1:0] exp_miss_q[$];

    always #5 clock = ~clock;

    domain_scheduler #(
        .NB_QUEUES     (NQ),
        .COUNTER_WIDTH (CW),
        .MODE_WIDTH    (MW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mode          (mode),
        .periods       (periods),
        .deadlines     (deadlines),
        .queue_empty   (queue_empty),
        .consumed      (consumed),
        .select        (select),
        .select_valid  (select_valid),
        .pop           (pop),
        .deadline_miss (deadline_miss)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Leaves the bench 1 time unit into cycle 0, the first cycle after the last reset edge.
    task automatic do_reset();
        reset    = 1'b0;
        consumed = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    // Scoreboard monitor: every observed pop / miss pulse must match the next expected entry.
    always @(negedge clock) begin
        if (pop !== '0 && !$isunknown(pop)) begin
            if (exp_pop_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop cycle %0d: got %b expected none", cyc, pop);
            end else begin
                check("pop", pop, exp_pop_q.pop_front());
            end
        end
        if (deadline_miss !== '0 && !$isunknown(deadline_miss)) begin
            if (exp_miss_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_miss cycle %0d: got %b expected none", cyc, deadline_miss);
            end else begin
                check("deadline_miss", deadline_miss, exp_miss_q.pop_front());
            end
        end
    end

    task automatic run_edf(input logic [NQ-1:0][CW-1:0] dl, input logic [3:0][1:0] order);
        logic [NQ-1:0] emp;
        mode        = 1'b1;
        periods     = {32'd100, 32'd100, 32'd100, 32'd100};
        deadlines   = dl;
        queue_empty = '0;
        do_reset();
        check("edf_idle_after_reset", select_valid, 1'b0);
        tick();
        check("edf_first_grant", {select_valid, select}, {1'b1, order[0]});
        emp      = '0;
        consumed = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_pop_q.push_back(NQ'(1) << order[k]);
            emp[order[k]] = 1'b1;
            queue_empty   = emp;
            tick();
        end
        consumed = 1'b0;
        check("edf_drained", select_valid, 1'b0);
    endtask

    initial begin
        // Reset state and TDMA alternation, periods {4,0,4,0}
        mode        = 1'b0;
        periods     = {32'd0, 32'd4, 32'd0, 32'd4};
        deadlines   = {32'd100, 32'd100, 32'd100, 32'd100};
        queue_empty = '0;
        do_reset();
        check("reset_select_valid", select_valid, 1'b0);
        check("reset_select", select, 2'd0);
        check("reset_miss", deadline_miss, '0);
        #1;
        check("reset_pop", pop, '0);
        for (int k = 0; k <= 26; k++) begin
            consumed = (k >= 5) && ((k - 5) % 4 == 0);
            if (consumed) begin
                exp_pop_q.push_back((((k - 5) / 4) % 2 == 0) ? 4'b0001 : 4'b0100);
            end
            if (k == 1) check("t1_first_grant", {select_valid, select}, 3'b100);
            if (k == 6) check("t1_second_grant", {select_valid, select}, 3'b110);
            check("t1_skip_zero_period", select_valid && (select == 2'd1 || select == 2'd3), 1'b0);
            tick();
        end
        consumed = 1'b0;

        // TDMA, only queue 0 non-empty, consumed held high
        periods     = {32'd3, 32'd3, 32'd3, 32'd3};
        queue_empty = 4'b1110;
        do_reset();
        consumed = 1'b1;
        repeat (2) exp_pop_q.push_back(4'b0001);
        repeat (2) exp_pop_q.push_back(4'b0001);
        repeat (2) exp_pop_q.push_back(4'b0001);
        for (int k = 0; k <= 24; k++) begin
            check("t2_valid_in_slot0", select_valid, (k >= 1) && ((k - 1) % 12 < 3));
            tick();
        end
        consumed = 1'b0;

        // Hold rule: queue 2 granted and held across slot boundaries
        queue_empty = 4'b1011;
        do_reset();
        repeat (6) tick();
        check("t3_not_yet", select_valid, 1'b0);
        tick();
        for (int k = 0; k < 20; k++) begin
            check("t3_hold", {select_valid, select}, 3'b110);
            tick();
        end
        consumed    = 1'b1;
        queue_empty = 4'b1111;
        exp_pop_q.push_back(4'b0100);
        tick();
        consumed = 1'b0;
        check("t3_released", select_valid, 1'b0);

        // EDF ordering and tie-break
        run_edf({32'd20, 32'd30, 32'd10, 32'd40}, {2'd0, 2'd2, 2'd3, 2'd1});
        run_edf({32'd30, 32'd10, 32'd10, 32'd30}, {2'd3, 2'd0, 2'd2, 2'd1});

        // EDF deadline miss, deadline 5, period 12
        mode        = 1'b1;
        periods     = {32'd0, 32'd0, 32'd0, 32'd12};
        deadlines   = {32'd100, 32'd100, 32'd100, 32'd5};
        queue_empty = 4'b1110;
        do_reset();
        for (int k = 0; k <= 18; k++) begin
            if (k == 5 || k == 17) exp_miss_q.push_back(4'b0001);
            if (k == 4 || k == 6 || k == 16) check("t5_miss_quiet", deadline_miss, '0);
            if (k == 10) check("t5_grant_held", {select_valid, select}, 3'b100);
            tick();
        end

        // Reset mid-grant
        mode        = 1'b0;
        periods     = {32'd0, 32'd4, 32'd0, 32'd4};
        deadlines   = {32'd20, 32'd30, 32'd10, 32'd40};
        queue_empty = '0;
        do_reset();
        tick();
        check("t6_granted", {select_valid, select}, 3'b100);
        reset = 1'b0;
        tick();
        reset    = 1'b1;
        consumed = 1'b1;
        #1;
        check("t6_reset_valid", select_valid, 1'b0);
        check("t6_reset_pop", pop, '0);
        tick();
        consumed = 1'b0;
        check("t6_regrant", {select_valid, select}, 3'b100);

        // Mode flip mid-grant: grant kept, next decision follows EDF
        do_reset();
        tick();
        tick();
        mode = 1'b1;
        tick();
        check("t7_grant_kept", {select_valid, select}, 3'b100);
        consumed = 1'b1;
        exp_pop_q.push_back(4'b0001);
        tick();
        consumed = 1'b0;
        check("t7_edf_select", {select_valid, select}, 3'b110);
        tick();

        check("pending_pops", exp_pop_q.size(), 0);
        check("pending_misses", exp_miss_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
